// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto one hardware stack port, tracking occupancy.
// Define STACK_ARB_FIXED_PRI_EN for fixed priority (requester 1 wins ties).
module stack_arbiter #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              op0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              op1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              stk_en,
   output logic              stk_rw,
   output logic [DATA_W-1:0] stk_din,
   input  logic [DATA_W-1:0] stk_dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state_q;
   logic              id_q;
   logic              op_q;
   logic              last_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              en_q;
   logic              rw_q;
   logic [DATA_W-1:0] din_q;
   logic [CNT_W-1:0]  count_q;
   logic              full_q;
   logic              empty_q;

   logic              win_d;
   logic              wop_d;
   logic [DATA_W-1:0] wdat_d;
   logic              rej_d;

   always_comb begin
      win_d = req1 & ~req0;
      if (req0 & req1) begin
`ifdef STACK_ARB_FIXED_PRI_EN
         win_d = 1'b1;
`else
         win_d = ~last_q;
`endif
      end
      wop_d  = win_d ? op1 : op0;
      wdat_d = win_d ? wdata1 : wdata0;
      rej_d  = wop_d ? empty_q : full_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         id_q    <= 1'b0;
         op_q    <= 1'b0;
         last_q  <= 1'b1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         en_q    <= 1'b0;
         rw_q    <= 1'b0;
         din_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req0 | req1) begin
                  id_q    <= win_d;
                  op_q    <= wop_d;
                  rdata_q <= '0;
                  if (rej_d) begin
                     // rejected ops never touch the stack
                     err_q   <= 1'b1;
                     ack0_q  <= ~win_d;
                     ack1_q  <= win_d;
                     state_q <= DONE;
                  end else begin
                     en_q    <= 1'b1;
                     rw_q    <= wop_d;
                     din_q   <= wop_d ? '0 : wdat_d;
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               en_q  <= 1'b0;
               rw_q  <= 1'b0;
               din_q <= '0;
               if (op_q) begin
                  count_q <= count_q - CNT_W'(1);
                  full_q  <= 1'b0;
                  empty_q <= (count_q == CNT_W'(1));
                  state_q <= WAIT;
               end else begin
                  count_q <= count_q + CNT_W'(1);
                  full_q  <= ((count_q + CNT_W'(1)) == CNT_W'(DEPTH));
                  empty_q <= 1'b0;
                  ack0_q  <= ~id_q;
                  ack1_q  <= id_q;
                  state_q <= DONE;
               end
            end
            WAIT: begin
               rdata_q <= stk_dout;
               ack0_q  <= ~id_q;
               ack1_q  <= id_q;
               state_q <= DONE;
            end
            DONE: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
               last_q  <= id_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign stk_en  = en_q;
   assign stk_rw  = rw_q;
   assign stk_din = din_q;
   assign count   = count_q;
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 8-deep stack.
// Build with STACK_ARB_FIXED_PRI_EN to check the fixed-priority variant.
module tb_stack_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
   logic [3:0] wdata0 = '0, wdata1 = '0;
   logic       ack0, ack1, err, stk_en, stk_rw, full, empty;
   logic [3:0] rdata, stk_din, count;
   logic [3:0] stk_dout;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   stack_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .err(err),
      .stk_en(stk_en), .stk_rw(stk_rw), .stk_din(stk_din),
      .stk_dout(stk_dout),
      .count(count), .full(full), .empty(empty)
   );

   // behavioural stack: pop data appears on dout after the sampling edge
   logic [3:0] mem [8];
   int         sp;
   always @(posedge clk) begin
      if (!rst) begin
         sp       <= 0;
         stk_dout <= '0;
      end else if (stk_en) begin
         if (!stk_rw) begin
            if (sp < 8) mem[sp] <= stk_din;
            if (sp < 8) sp <= sp + 1;
         end else if (sp > 0) begin
            stk_dout <= mem[sp-1];
            sp       <= sp - 1;
         end
      end
   end

   task automatic run_op(input int id, input logic op,
                         input logic [3:0] d, output int lat,
                         output logic [3:0] rd, output logic er,
                         output int ens, output logic enrw,
                         output logic badack);
      @(negedge clk);
      if (id == 0) begin req0 = 1'b1; op0 = op; wdata0 = d; end
      else begin req1 = 1'b1; op1 = op; wdata1 = d; end
      lat = 0; ens = 0; enrw = 1'b0; rd = '0; er = 1'b0;
      badack = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (stk_en) begin ens++; enrw = stk_rw; end
         if ((id == 0 && ack1) || (id == 1 && ack0)) badack = 1'b1;
         if (ack0 | ack1) begin
            lat = k; rd = rdata; er = err;
            break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({count, empty, full, stk_en, ack0, ack1} !== {4'd0, 5'b10000}) begin
         $display("FAIL reset_state: got cnt=%0d e=%b f=%b en=%b a0=%b a1=%b",
                  count, empty, full, stk_en, ack0, ack1);
      end else passed++;
   endtask

   task automatic test_push_pop;
      int lat, ens; logic [3:0] rd; logic er, rw, bad;
      run_op(0, 1'b0, 4'h7, lat, rd, er, ens, rw, bad);
      total++;
      if ({lat, ens, 1'(rw), er, bad, count} !== {32'd2, 32'd1, 3'b000, 4'd1})
         $display("FAIL push7: lat=%0d ens=%0d rw=%b err=%b bad=%b cnt=%0d want 2 1 0 0 0 1",
                  lat, ens, rw, er, bad, count);
      else passed++;
      run_op(0, 1'b1, 4'h0, lat, rd, er, ens, rw, bad);
      total++;
      if ({lat, ens, 1'(rw), er, bad, count, rd} !== {32'd2+32'd1, 32'd1, 3'b100, 4'd0, 4'h7})
         $display("FAIL pop7: lat=%0d ens=%0d rw=%b err=%b bad=%b cnt=%0d rd=%h want 3 1 1 0 0 0 7",
                  lat, ens, rw, er, bad, count, rd);
      else passed++;
      total++;
      if (empty !== 1'b1) $display("FAIL empty_after_pop: got %b want 1", empty);
      else passed++;
   endtask

   task automatic test_lifo;
      int lat, ens; logic [3:0] rd; logic er, rw, bad;
      run_op(0, 1'b0, 4'h8, lat, rd, er, ens, rw, bad);
      run_op(1, 1'b0, 4'hA, lat, rd, er, ens, rw, bad);
      total++;
      if (lat !== 2 || bad !== 1'b0 || count !== 4'd2)
         $display("FAIL lifo_push1: lat=%0d bad=%b cnt=%0d want 2 0 2", lat, bad, count);
      else passed++;
      run_op(0, 1'b1, 4'h0, lat, rd, er, ens, rw, bad);
      total++;
      if (rd !== 4'hA || bad !== 1'b0 || lat !== 3)
         $display("FAIL lifo_pop0: rd=%h bad=%b lat=%0d want A 0 3", rd, bad, lat);
      else passed++;
      run_op(1, 1'b1, 4'h0, lat, rd, er, ens, rw, bad);
      total++;
      if (rd !== 4'h8 || bad !== 1'b0 || count !== 4'd0)
         $display("FAIL lifo_pop1: rd=%h bad=%b cnt=%0d want 8 0 0", rd, bad, count);
      else passed++;
   endtask

   task automatic test_boundaries;
      int lat, ens; logic [3:0] rd; logic er, rw, bad;
      run_op(0, 1'b1, 4'h0, lat, rd, er, ens, rw, bad);
      total++;
      if (lat !== 1 || er !== 1'b1 || ens !== 0 || count !== 4'd0 || rd !== 4'h0)
         $display("FAIL pop_empty: lat=%0d err=%b ens=%0d cnt=%0d rd=%h want 1 1 0 0 0",
                  lat, er, ens, count, rd);
      else passed++;
      for (int i = 1; i <= 8; i++)
         run_op(i % 2, 1'b0, 4'(i), lat, rd, er, ens, rw, bad);
      total++;
      if (full !== 1'b1 || count !== 4'd8)
         $display("FAIL fill: full=%b cnt=%0d want 1 8", full, count);
      else passed++;
      run_op(0, 1'b0, 4'h9, lat, rd, er, ens, rw, bad);
      total++;
      if (lat !== 1 || er !== 1'b1 || ens !== 0 || count !== 4'd8)
         $display("FAIL push_full: lat=%0d err=%b ens=%0d cnt=%0d want 1 1 0 8",
                  lat, er, ens, count);
      else passed++;
      for (int i = 8; i >= 1; i--) begin
         run_op(0, 1'b1, 4'h0, lat, rd, er, ens, rw, bad);
         total++;
         if (rd !== 4'(i) || er !== 1'b0 || count !== 4'(i - 1))
            $display("FAIL drain%0d: rd=%h err=%b cnt=%0d want %h 0 %0d",
                     i, rd, er, count, 4'(i), i - 1);
         else passed++;
      end
      total++;
      if (empty !== 1'b1 || full !== 1'b0)
         $display("FAIL drained_flags: e=%b f=%b want 1 0", empty, full);
      else passed++;
   endtask

   task automatic serve_pair(input int round, input int want_first);
      int first, second;
      first = -1; second = -1;
      for (int k = 0; k < 20 && second < 0; k++) begin
         @(posedge clk); #1;
         if (ack0 | ack1) begin
            if (first < 0) first = ack1 ? 1 : 0;
            else second = ack1 ? 1 : 0;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
         end
      end
      total++;
      if (first !== want_first || second !== 1 - want_first)
         $display("FAIL contention%0d: order %0d,%0d want %0d,%0d",
                  round, first, second, want_first, 1 - want_first);
      else passed++;
   endtask

   task automatic test_contention;
      int want;
`ifdef STACK_ARB_FIXED_PRI_EN
      want = 1;
`else
      want = 0;
`endif
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; op0 = 1'b0; wdata0 = 4'h3;
      req1 = 1'b1; op1 = 1'b0; wdata1 = 4'h5;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      serve_pair(1, want);
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1;
      serve_pair(2, want);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      total++;
      if (count !== 4'd4)
         $display("FAIL contention_count: got %0d want 4", count);
      else passed++;
   endtask

   task automatic test_reset_midop;
      int lat, ens; logic [3:0] rd; logic er, rw, bad;
      logic seen;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      run_op(0, 1'b0, 4'h7, lat, rd, er, ens, rw, bad);
      @(negedge clk);
      req0 = 1'b1; op0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; req0 = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack0 | ack1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0 || count !== 4'd0 || empty !== 1'b1)
         $display("FAIL reset_midop: ack_seen=%b cnt=%0d e=%b want 0 0 1",
                  seen, count, empty);
      else passed++;
      @(negedge clk); rst = 1'b1;
      run_op(0, 1'b0, 4'h4, lat, rd, er, ens, rw, bad);
      total++;
      if (lat !== 2 || er !== 1'b0 || count !== 4'd1)
         $display("FAIL push_after_reset: lat=%0d err=%b cnt=%0d want 2 0 1",
                  lat, er, count);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_push_pop;
      test_lifo;
      test_boundaries;
      test_contention;
      test_reset_midop;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
